// File: rtl/zoom_pkg.sv
// zoom_pkg: frame geometry, address width and FSM states shared by the zoom engines
package zoom_pkg;
    localparam int SRC_W   = 160;
    localparam int SRC_H   = 120;
    localparam int DST_W   = 2 * SRC_W;
    localparam int DST_H   = 2 * SRC_H;
    localparam int ADDR_W  = 17;
    localparam int SRC_PIX = SRC_W * SRC_H;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ_WAIT,
        ST_WR00,
        ST_WR01,
        ST_WR10,
        ST_WR11,
        ST_FINISH
    } zoom_state_e;
endpackage

// File: rtl/zoom_addr_map.sv
// zoom_addr_map: registered source-index to destination 2x2 block base address
module zoom_addr_map
    import zoom_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  addr_t i_addr,
    output addr_t o_base
);
    addr_t w_row;
    addr_t w_col;
    addr_t r_base;
    assign w_row  = i_addr / addr_t'(SRC_W);
    assign w_col  = i_addr % addr_t'(SRC_W);
    assign o_base = r_base;
    // Row 2r of the destination starts at r*2*DST_W; column 2c within it.
    always_ff @(posedge clk) begin
        if (rst) r_base <= '0;
        else     r_base <= w_row * addr_t'(2 * DST_W) + (w_col << 1);
    end
endmodule

// File: rtl/address_pixel_replicate.sv
// address_pixel_replicate: 2x nearest-neighbour zoom, one source pixel to a 2x2 destination block
module address_pixel_replicate
    import zoom_pkg::*;
#(
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [16:0] in_address,
    input  logic [7:0]  in_data,
    output logic [16:0] mem_read_addr,
    output logic [16:0] out_address,
    output logic [7:0]  out_data,
    output logic        out_wren,
    output logic        busy,
    output logic        done,
    output logic        err
);
    zoom_state_e r_state;
    zoom_state_e w_next;
    logic [1:0]  r_cnt;
    addr_t       r_addr;
    logic [7:0]  r_pixel;
    addr_t       r_mem_read_addr;
    addr_t       r_out_address;
    logic [7:0]  r_out_data;
    logic        r_out_wren;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    addr_t       w_base;
    addr_t       w_off;
    logic        w_idle;
    logic        w_in_range;
    logic        w_accept;
    logic        w_wr;

    // Base address is ready one cycle after latching, well inside READ_WAIT.
    zoom_addr_map u_map (
        .clk    (clk),
        .rst    (rst),
        .i_addr (r_addr),
        .o_base (w_base)
    );

    assign w_idle     = r_state == ST_IDLE;
    assign w_in_range = in_address < addr_t'(SRC_PIX);
    assign w_accept   = w_idle && start && w_in_range;
    assign w_wr       = r_state inside {ST_WR00, ST_WR01, ST_WR10, ST_WR11};
    assign w_off      = (r_state == ST_WR00) ? addr_t'(0) :
                        (r_state == ST_WR01) ? addr_t'(1) :
                        (r_state == ST_WR10) ? addr_t'(DST_W) : addr_t'(DST_W + 1);

    // Next-state: wait out the RAM latency, then walk the four block writes.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      w_next = w_accept ? ST_READ_WAIT : ST_IDLE;
            ST_READ_WAIT: w_next = (r_cnt == 2'd0) ? ST_WR00 : ST_READ_WAIT;
            ST_WR00:      w_next = ST_WR01;
            ST_WR01:      w_next = ST_WR10;
            ST_WR10:      w_next = ST_WR11;
            ST_WR11:      w_next = ST_FINISH;
            default:      w_next = ST_IDLE;
        endcase
    end

    // State register plus registered outputs; reset aborts any request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_addr          <= '0;
            r_pixel         <= '0;
            r_mem_read_addr <= '0;
            r_out_address   <= '0;
            r_out_data      <= '0;
            r_out_wren      <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_err      <= w_idle && start && !w_in_range;
            r_done     <= r_state == ST_FINISH;
            r_busy     <= w_accept ? 1'b1 : (r_state == ST_FINISH) ? 1'b0 : r_busy;
            r_out_wren <= w_wr;
            if (w_accept) begin
                r_addr          <= in_address;
                r_mem_read_addr <= in_address;
                r_cnt           <= 2'(READ_LAT);
            end
            if (r_state == ST_READ_WAIT) begin
                if (r_cnt == 2'd0) r_pixel <= in_data;
                else               r_cnt   <= r_cnt - 2'd1;
            end
            if (w_wr) begin
                r_out_address <= w_base + w_off;
                r_out_data    <= r_pixel;
            end
        end
    end

    assign mem_read_addr = r_mem_read_addr;
    assign out_address   = r_out_address;
    assign out_data      = r_out_data;
    assign out_wren      = r_out_wren;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
endmodule

// File: tb/tb_address_pixel_replicate.sv
// tb_address_pixel_replicate: scoreboard bench with a frame-geometry reference model
module tb_address_pixel_replicate;
    localparam int LAT  = 2;
    localparam int NPIX = 160 * 120;

    typedef struct {
        int          cyc;
        logic [16:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [16:0] in_address = '0;
    logic [7:0]  in_data;
    logic [16:0] mem_read_addr;
    logic [16:0] out_address;
    logic [7:0]  out_data;
    logic        out_wren;
    logic        busy;
    logic        done;
    logic        err;

    logic [7:0] ram [NPIX];
    logic [7:0] pipe [3];

    wr_t wq[$];
    int  dq[$];
    int  eq[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  free_at = 0;
    int  cur_s = 0;
    int  busy_end = 0;
    bit  have_cur = 1'b0;

    address_pixel_replicate #(.READ_LAT(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_address    (in_address),
        .in_data       (in_data),
        .mem_read_addr (mem_read_addr),
        .out_address   (out_address),
        .out_data      (out_data),
        .out_wren      (out_wren),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Source RAM whose data becomes valid LAT cycles after the address changes.
    always @(posedge clk) begin
        pipe[0] <= (int'(mem_read_addr) < NPIX) ? ram[mem_read_addr] : 8'h00;
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end
    assign in_data = pipe[LAT-1];

    // Monitor: compare every cycle's outputs with the scoreboard heads.
    always @(negedge clk) begin
        bit exp_wr;
        bit exp_done;
        bit exp_err;
        bit exp_busy;
        exp_wr   = wq.size() > 0 && wq[0].cyc == cyc;
        exp_done = dq.size() > 0 && dq[0] == cyc;
        exp_err  = eq.size() > 0 && eq[0] == cyc;
        exp_busy = have_cur && cyc >= cur_s && cyc < busy_end;
        checks++;
        if (out_wren !== exp_wr) begin
            errors++;
            $display("FAIL wren cyc=%0d got=%b exp=%b", cyc, out_wren, exp_wr);
        end else if (exp_wr) begin
            checks++;
            if (out_address !== wq[0].addr || out_data !== wq[0].data) begin
                errors++;
                $display("FAIL write cyc=%0d got addr=%0d data=%h exp addr=%0d data=%h",
                         cyc, out_address, out_data, wq[0].addr, wq[0].data);
            end
        end
        if (exp_wr) void'(wq.pop_front());
        checks++;
        if (done !== exp_done) begin
            errors++;
            $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, exp_done);
        end
        if (exp_done) void'(dq.pop_front());
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL err cyc=%0d got=%b exp=%b", cyc, err, exp_err);
        end
        if (exp_err) void'(eq.pop_front());
        checks++;
        if (busy !== exp_busy) begin
            errors++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one start pulse and record what the frame model says must follow.
    task automatic issue(input logic [16:0] a);
        int s;
        int r;
        int c;
        s = cyc + 1;
        start = 1'b1;
        in_address = a;
        if (s >= free_at) begin
            if (int'(a) < NPIX) begin
                r = int'(a) / 160;
                c = int'(a) % 160;
                for (int k = 0; k < 4; k++) begin
                    wr_t w;
                    w.cyc  = s + LAT + 2 + k;
                    w.addr = 17'((2 * r + k / 2) * 320 + 2 * c + k % 2);
                    w.data = ram[a];
                    wq.push_back(w);
                end
                dq.push_back(s + LAT + 6);
                have_cur = 1'b1;
                cur_s    = s;
                busy_end = s + LAT + 6;
                free_at  = s + LAT + 7;
            end else begin
                eq.push_back(s);
            end
        end
        step();
        start = 1'b0;
        in_address = 17'($urandom);
    endtask

    task automatic wait_idle();
        while (cyc + 1 < free_at) step();
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({mem_read_addr, out_address, out_data, out_wren, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL %s got rd=%0d wa=%0d wd=%h wren=%b busy=%b done=%b err=%b exp all zero",
                     name, mem_read_addr, out_address, out_data, out_wren, busy, done, err);
        end
    endtask

    initial begin
        int s;
        int cut;
        logic [16:0] a;
        for (int i = 0; i < NPIX; i++) ram[i] = 8'($urandom);
        ram[0]   = 8'hAB;
        ram[159] = 8'h12;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;
        step();
        issue(17'd0);     wait_idle();
        issue(17'd159);   wait_idle();
        issue(17'd160);   wait_idle();
        issue(17'd19199); wait_idle();
        issue(17'd19200); wait_idle();
        issue(17'd131071); wait_idle();
        issue(17'd500);
        repeat (LAT + 2) step();
        issue(17'd777);
        wait_idle();
        issue(17'd1000);
        s = cyc;
        while (cyc < s + LAT + 5) step();
        issue(17'd2000);
        issue(17'd3000);
        wait_idle();
        issue(17'd4321);
        s = cyc;
        repeat (LAT + 4) step();
        rst = 1'b1;
        cut = s + LAT + 5;
        while (wq.size() > 0 && wq[$].cyc >= cut) void'(wq.pop_back());
        dq.delete();
        busy_end = cut;
        free_at  = cut + 1;
        @(posedge clk);
        @(negedge clk);
        check_zero("abort_reset");
        rst = 1'b0;
        step();
        issue(17'd42);
        wait_idle();
        for (int i = 0; i < 250; i++) begin
            repeat ($urandom_range(0, 10)) begin
                step();
                in_address = 17'($urandom);
            end
            case ($urandom_range(0, 9))
                0:       a = 17'($urandom_range(NPIX, 131071));
                1:       a = 17'($urandom_range(0, 119) * 160 + 159);
                default: a = 17'($urandom_range(0, NPIX - 1));
            endcase
            issue(a);
        end
        wait_idle();
        repeat (LAT + 12) step();
        checks++;
        if (wq.size() + dq.size() + eq.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d exp 0", wq.size() + dq.size() + eq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
